m68k_bus_responder: RTL and testbench
=====================================

# m68k_bus_responder

Responder side of the 68000 bus: consumes the per-region chip selects produced by the address decoder, sequences each access through a wait-state state machine, returns read data on `cpu_din`, and drives `cpu_dtack_n` (and optionally `cpu_berr_n`) back to the CPU. It sits between the chip-select decoder and the 68000 core, alongside the SDRAM ROM fetcher and on-chip RAMs.

## Interface
- `RAM_WAIT`, 1, cycles from select to data-valid for work RAM and shared RAM (0–15)
- `IO_WAIT`, 0, cycles from select to acknowledge for register/palette/video selects (0–15)
- `BERR_TIMEOUT`, 255, cycles an unmapped access waits before bus error (1–255)

- `clk_sys`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `cpu_as_n`  in  1  68000 address strobe
- `cpu_rw`  in  1  1 = read, 0 = write
- `rom_cs`, `ram_cs`, `shared_ram_cs`, `io_cs`  in  1 each  region selects from the decoder (`io_cs` = OR of all register selects)
- `rom_data`  in  16  SDRAM ROM word
- `rom_valid`  in  1  one-cycle pulse, `rom_data` valid
- `ram_data`  in  16  work RAM read word
- `shared_ram_data`  in  8  Z80 shared RAM byte
- `io_data`  in  16  register/palette read word
- `rom_req`  out  1  one-cycle ROM fetch request
- `cpu_din`  out  16  read data to CPU
- `cpu_dtack_n`  out  1  data acknowledge, active-low
- `cpu_berr_n`  out  1  bus error, active-low

## Operation
- States: IDLE, ROM_WAIT, CNT_WAIT, ACK, BERR.
- IDLE: when `cpu_as_n`=0, sample selects with priority rom > ram > shared_ram > io; latch source.
  - rom: pulse `rom_req` (reads and writes), go ROM_WAIT.
  - ram/shared_ram: load counter with `RAM_WAIT`, go CNT_WAIT; io: load `IO_WAIT`, go CNT_WAIT.
  - none: load counter with `BERR_TIMEOUT`, go CNT_WAIT tagged unmapped.
- ROM_WAIT: on `rom_valid`, latch `rom_data` if read, go ACK.
- CNT_WAIT: counter zero → latch source data if read, go ACK (unmapped: see Configuration); else decrement.
- Shared RAM read returns {8'hFF, `shared_ram_data`}.
- Writes never update `cpu_din` (holds last read value).
- ACK: `cpu_dtack_n`=0 until `cpu_as_n` seen high, then IDLE.
- Abort: `cpu_as_n` high in ROM_WAIT/CNT_WAIT → IDLE with no acknowledge; a later `rom_valid` is ignored.
- Counter width 8 bits; no wrap (stops at zero).

## Timing
- Reset: state IDLE, `cpu_dtack_n`=1, `cpu_berr_n`=1, `rom_req`=0, `cpu_din`=16'h0000, counter 0.
- All outputs registered.
- `rom_req` high exactly one cycle, cycle after AS sampled low.
- ROM: `cpu_dtack_n` falls 1 cycle after the `rom_valid` cycle; `cpu_din` valid same edge.
- Counted regions: `cpu_dtack_n` falls N+2 cycles after first AS-low cycle (N = wait value); N=0 gives 2.
- `cpu_dtack_n`/`cpu_berr_n` rise the edge after `cpu_as_n` sampled high; IDLE can accept a new AS-low on the following cycle.
- `rom_valid` coinciding with AS-high in ROM_WAIT: abort wins, no acknowledge.
- Reset mid-access overrides everything, outputs return to reset values next edge.

## Configuration
- `M68K_BERR_EN` defined: unmapped access reaching zero count goes to BERR; `cpu_berr_n`=0 until AS high, `cpu_dtack_n` stays 1, `cpu_din` unchanged.
- Not defined: unmapped access uses `IO_WAIT` instead of `BERR_TIMEOUT`, acknowledged via ACK with `cpu_din`=16'hFFFF on reads; `cpu_berr_n` tied to 1, BERR state absent.

## Structure
- Package `m68k_bus_pkg`: state enum, source enum (SRC_ROM, SRC_RAM, SRC_SHARED, SRC_IO, SRC_NONE), open-bus constant 16'hFFFF, shared-RAM fill byte 8'hFF.
- Sub-module `bus_wait_counter`: 8-bit loadable down-counter with load, enable, zero flag.

## Test plan
- ROM read, `rom_valid` 5 cycles after `rom_req`, `rom_data`=16'h4E71 → `cpu_din`=16'h4E71, DTACK low cycle after valid, high cycle after AS rises.
- RAM_WAIT=1 read, `ram_data`=16'h1234 → DTACK low 3 cycles after AS low, `cpu_din`=16'h1234.
- Shared RAM read, byte 8'h5A → `cpu_din`=16'hFF5A; io write → `cpu_din` unchanged, DTACK at IO_WAIT+2.
- AS released during ROM_WAIT, then stray `rom_valid` → no DTACK, state IDLE, next access correct.
- Unmapped read: with `M68K_BERR_EN`, BERR_TIMEOUT=4 → `cpu_berr_n` low, DTACK high; without → DTACK low, `cpu_din`=16'hFFFF.
- `reset` asserted in ACK → `cpu_dtack_n`=1, `cpu_din`=0 next edge, IDLE.

Source files
------------

// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000 bus responder.
// Defining M68K_BERR_EN adds the bus-error state for unmapped accesses.
package m68k_bus_pkg;

    localparam int unsigned CNT_W       = 8;
    localparam logic [15:0] OPEN_BUS    = 16'hFFFF;
    localparam logic [7:0]  SHARED_FILL = 8'hFF;

`ifdef M68K_BERR_EN
    localparam bit BERR_EN = 1'b1;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROM_WAIT,
        ST_CNT_WAIT,
        ST_ACK,
        ST_BERR
    } state_t;
`else
    localparam bit BERR_EN = 1'b0;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROM_WAIT,
        ST_CNT_WAIT,
        ST_ACK
    } state_t;
`endif

    typedef enum logic [2:0] {
        SRC_ROM,
        SRC_RAM,
        SRC_SHARED,
        SRC_IO,
        SRC_NONE
    } src_t;

    // Region priority: rom > ram > shared_ram > io.
    function automatic src_t sel_source(input logic rom_cs, input logic ram_cs,
                                        input logic shared_cs, input logic io_cs);
        if (rom_cs)         return SRC_ROM;
        else if (ram_cs)    return SRC_RAM;
        else if (shared_cs) return SRC_SHARED;
        else if (io_cs)     return SRC_IO;
        else                return SRC_NONE;
    endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Loadable 8-bit down-counter that holds at zero; sequences wait states.
module bus_wait_counter
    import m68k_bus_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/m68k_bus_responder.sv
// 68000 bus responder: wait-state sequencing, read data return and DTACK/BERR.
// Defining M68K_BERR_EN turns unmapped accesses into bus errors after BERR_TIMEOUT.
module m68k_bus_responder
    import m68k_bus_pkg::*;
#(
    parameter int unsigned RAM_WAIT     = 1,
    parameter int unsigned IO_WAIT      = 0,
    parameter int unsigned BERR_TIMEOUT = 255
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cpu_as_n,
    input  logic        cpu_rw,
    input  logic        rom_cs,
    input  logic        ram_cs,
    input  logic        shared_ram_cs,
    input  logic        io_cs,
    input  logic [15:0] rom_data,
    input  logic        rom_valid,
    input  logic [15:0] ram_data,
    input  logic [7:0]  shared_ram_data,
    input  logic [15:0] io_data,
    output logic        rom_req,
    output logic [15:0] cpu_din,
    output logic        cpu_dtack_n,
    output logic        cpu_berr_n
);

    localparam logic [CNT_W-1:0] RAM_LOAD  = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] IO_LOAD   = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] NONE_LOAD = BERR_EN ? CNT_W'(BERR_TIMEOUT) : CNT_W'(IO_WAIT);

    state_t      r_state, w_state_nxt;
    src_t        r_src, w_src_nxt;
    logic        r_rw, w_rw_nxt;
    logic        r_rom_req, w_rom_req_nxt;
    logic        r_dtack_n, w_dtack_n_nxt;
    logic [15:0] r_din, w_din_nxt;
    logic        w_berr_n_nxt;

    src_t             w_sel_src;
    logic [15:0]      w_src_data;
    logic [CNT_W-1:0] w_load_val;
    logic             w_cnt_load;
    logic             w_cnt_en;
    logic             w_cnt_zero;

    assign w_sel_src = sel_source(rom_cs, ram_cs, shared_ram_cs, io_cs);

    bus_wait_counter u_wait_cnt (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_en       (w_cnt_en),
        .i_load_val (w_load_val),
        .o_zero_c   (w_cnt_zero)
    );

    // Wait count loaded on the select cycle and read word for the latched source.
    always_comb begin
        w_load_val = NONE_LOAD;
        w_src_data = OPEN_BUS;
        case (w_sel_src)
            SRC_RAM, SRC_SHARED: w_load_val = RAM_LOAD;
            SRC_IO:              w_load_val = IO_LOAD;
            default:             w_load_val = NONE_LOAD;
        endcase
        case (r_src)
            SRC_RAM:    w_src_data = ram_data;
            SRC_SHARED: w_src_data = {SHARED_FILL, shared_ram_data};
            SRC_IO:     w_src_data = io_data;
            default:    w_src_data = OPEN_BUS;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_src_nxt     = r_src;
        w_rw_nxt      = r_rw;
        w_rom_req_nxt = 1'b0;
        w_dtack_n_nxt = 1'b1;
        w_berr_n_nxt  = 1'b1;
        w_din_nxt     = r_din;
        w_cnt_load    = 1'b0;
        w_cnt_en      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!cpu_as_n) begin
                    w_src_nxt = w_sel_src;
                    w_rw_nxt  = cpu_rw;
                    if (w_sel_src == SRC_ROM) begin
                        w_rom_req_nxt = 1'b1;
                        w_state_nxt   = ST_ROM_WAIT;
                    end else begin
                        w_cnt_load  = 1'b1;
                        w_state_nxt = ST_CNT_WAIT;
                    end
                end
            end
            // AS release aborts and outranks a coincident rom_valid.
            ST_ROM_WAIT: begin
                if (cpu_as_n) begin
                    w_state_nxt = ST_IDLE;
                end else if (rom_valid) begin
                    w_state_nxt   = ST_ACK;
                    w_dtack_n_nxt = 1'b0;
                    if (r_rw) w_din_nxt = rom_data;
                end
            end
            ST_CNT_WAIT: begin
                if (cpu_as_n) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_zero) begin
`ifdef M68K_BERR_EN
                    if (r_src == SRC_NONE) begin
                        w_state_nxt  = ST_BERR;
                        w_berr_n_nxt = 1'b0;
                    end else begin
                        w_state_nxt   = ST_ACK;
                        w_dtack_n_nxt = 1'b0;
                        if (r_rw) w_din_nxt = w_src_data;
                    end
`else
                    w_state_nxt   = ST_ACK;
                    w_dtack_n_nxt = 1'b0;
                    if (r_rw) w_din_nxt = w_src_data;
`endif
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_ACK: begin
                if (cpu_as_n) w_state_nxt = ST_IDLE;
                else          w_dtack_n_nxt = 1'b0;
            end
`ifdef M68K_BERR_EN
            ST_BERR: begin
                if (cpu_as_n) w_state_nxt = ST_IDLE;
                else          w_berr_n_nxt = 1'b0;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_src     <= SRC_NONE;
            r_rw      <= 1'b1;
            r_rom_req <= 1'b0;
            r_dtack_n <= 1'b1;
            r_din     <= 16'h0000;
        end else begin
            r_state   <= w_state_nxt;
            r_src     <= w_src_nxt;
            r_rw      <= w_rw_nxt;
            r_rom_req <= w_rom_req_nxt;
            r_dtack_n <= w_dtack_n_nxt;
            r_din     <= w_din_nxt;
        end
    end

`ifdef M68K_BERR_EN
    logic r_berr_n;

    always_ff @(posedge clk_sys) begin
        if (reset) r_berr_n <= 1'b1;
        else       r_berr_n <= w_berr_n_nxt;
    end

    assign cpu_berr_n = r_berr_n;
`else
    logic w_berr_unused;

    assign w_berr_unused = w_berr_n_nxt;
    assign cpu_berr_n    = 1'b1;
`endif

    assign rom_req     = r_rom_req;
    assign cpu_din     = r_din;
    assign cpu_dtack_n = r_dtack_n;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: cycle-arithmetic model checked every cycle
// plus literal expectations for each scenario.
module tb_m68k_bus_responder;

    localparam int RAM_W  = 1;
    localparam int IO_W   = 0;
    localparam int BERR_T = 4;
`ifdef M68K_BERR_EN
    localparam bit BERR_MODE = 1'b1;
`else
    localparam bit BERR_MODE = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        cpu_as_n, cpu_rw;
    logic        rom_cs, ram_cs, shared_ram_cs, io_cs;
    logic [15:0] rom_data, ram_data, io_data;
    logic        rom_valid;
    logic [7:0]  shared_ram_data;
    logic        rom_req, cpu_dtack_n, cpu_berr_n;
    logic [15:0] cpu_din;

    int n_checks = 0;
    int n_fail   = 0;

    m68k_bus_responder #(.RAM_WAIT(RAM_W), .IO_WAIT(IO_W), .BERR_TIMEOUT(BERR_T)) dut (
        .clk_sys(clk_sys), .reset(reset), .cpu_as_n(cpu_as_n), .cpu_rw(cpu_rw),
        .rom_cs(rom_cs), .ram_cs(ram_cs), .shared_ram_cs(shared_ram_cs), .io_cs(io_cs),
        .rom_data(rom_data), .rom_valid(rom_valid), .ram_data(ram_data),
        .shared_ram_data(shared_ram_data), .io_data(io_data), .rom_req(rom_req),
        .cpu_din(cpu_din), .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each access is timed by absolute edge numbers rather than states.
    int          m_cyc = 0;
    bit          m_valid = 0;
    bit          m_act = 0, m_acked = 0, m_rd = 0, m_berr = 0;
    int          m_kind = 0;   // 0 rom, 1 ram, 2 shared, 3 io, 4 unmapped
    int          m_due = 0;
    logic [15:0] m_din = 16'h0000;
    logic        e_dtack_n, e_berr_n, e_rom_req;
    logic [15:0] e_din;

    function automatic logic [15:0] src_word(input int kind);
        case (kind)
            1:       return ram_data;
            2:       return {8'hFF, shared_ram_data};
            3:       return io_data;
            default: return 16'hFFFF;
        endcase
    endfunction

    always @(posedge clk_sys) begin
        int n;
        m_cyc++;
        m_valid = 1'b1;
        e_rom_req = 1'b0;
        if (reset) begin
            m_act = 0; m_acked = 0; m_din = 16'h0000;
        end else if (!m_act) begin
            if (!cpu_as_n) begin
                m_act = 1; m_acked = 0; m_rd = cpu_rw; m_berr = 0;
                if (rom_cs) begin
                    m_kind = 0; e_rom_req = 1'b1;
                end else begin
                    if (ram_cs)             begin m_kind = 1; n = RAM_W; end
                    else if (shared_ram_cs) begin m_kind = 2; n = RAM_W; end
                    else if (io_cs)         begin m_kind = 3; n = IO_W;  end
                    else begin
                        m_kind = 4; n = BERR_MODE ? BERR_T : IO_W; m_berr = BERR_MODE;
                    end
                    m_due = m_cyc + n + 1;
                end
            end
        end else if (cpu_as_n) begin
            m_act = 0; m_acked = 0;
        end else if (!m_acked) begin
            if (m_kind == 0 ? rom_valid : (m_cyc == m_due)) begin
                m_acked = 1;
                if (m_rd && !m_berr) m_din = (m_kind == 0) ? rom_data : src_word(m_kind);
            end
        end
        e_dtack_n = !(m_act && m_acked && !m_berr);
        e_berr_n  = !(m_act && m_acked && m_berr);
        e_din     = m_din;
    end

    always @(negedge clk_sys) begin
        if (m_valid) begin
            chk1("model_dtack_n", cpu_dtack_n, e_dtack_n);
            chk1("model_berr_n", cpu_berr_n, e_berr_n);
            chk1("model_rom_req", rom_req, e_rom_req);
            chk("model_din", cpu_din, e_din);
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic begin_acc(input logic rw, input logic [3:0] cs);
        cpu_as_n = 1'b0;
        cpu_rw   = rw;
        {rom_cs, ram_cs, shared_ram_cs, io_cs} = cs;
    endtask

    task automatic end_acc();
        cpu_as_n = 1'b1;
        cpu_rw   = 1'b1;
        {rom_cs, ram_cs, shared_ram_cs, io_cs} = 4'b0000;
        tick();
        chk1("release_dtack_n", cpu_dtack_n, 1'b1);
        chk1("release_berr_n", cpu_berr_n, 1'b1);
    endtask

    // Cycles from the first AS-low cycle until DTACK or BERR is seen low, bounded.
    task automatic wait_ack(output int lat);
        lat = 0;
        while (cpu_dtack_n && cpu_berr_n && lat < 400) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        reset = 1'b1; cpu_as_n = 1'b1; cpu_rw = 1'b1;
        {rom_cs, ram_cs, shared_ram_cs, io_cs} = 4'b0000;
        rom_data = 16'h0000; rom_valid = 1'b0; ram_data = 16'h0000;
        shared_ram_data = 8'h00; io_data = 16'h0000;
        tick(); tick();
        chk1("reset_dtack_n", cpu_dtack_n, 1'b1);
        chk1("reset_berr_n", cpu_berr_n, 1'b1);
        chk1("reset_rom_req", rom_req, 1'b0);
        chk("reset_din", cpu_din, 16'h0000);
        reset = 1'b0;
        tick();

        // ROM read, rom_valid five cycles after rom_req
        begin_acc(1'b1, 4'b1000);
        tick(); chk1("rom_req_pulse", rom_req, 1'b1);
        tick(); chk1("rom_req_one_cycle", rom_req, 1'b0);
        repeat (4) tick();
        rom_valid = 1'b1; rom_data = 16'h4E71;
        chk1("rom_no_early_dtack", cpu_dtack_n, 1'b1);
        tick(); rom_valid = 1'b0;
        chk1("rom_dtack_after_valid", cpu_dtack_n, 1'b0);
        chk("rom_read_data", cpu_din, 16'h4E71);
        tick(); tick();
        end_acc();

        // Work RAM read
        ram_data = 16'h1234;
        begin_acc(1'b1, 4'b0100);
        wait_ack(lat);
        chk_int("ram_latency", lat, RAM_W + 2);
        chk("ram_read_data", cpu_din, 16'h1234);
        end_acc();

        // Shared RAM read fills the upper byte
        shared_ram_data = 8'h5A;
        begin_acc(1'b1, 4'b0010);
        wait_ack(lat);
        chk_int("shared_latency", lat, 3);
        chk("shared_read_data", cpu_din, 16'hFF5A);
        end_acc();

        // IO write leaves cpu_din alone
        io_data = 16'hBEEF;
        begin_acc(1'b0, 4'b0001);
        wait_ack(lat);
        chk_int("io_write_latency", lat, IO_W + 2);
        chk("io_write_din_held", cpu_din, 16'hFF5A);
        end_acc();

        // ROM wins priority over RAM; ROM write still requests and acknowledges
        begin_acc(1'b0, 4'b1100);
        tick(); chk1("prio_rom_req", rom_req, 1'b1);
        tick(); tick();
        rom_valid = 1'b1; rom_data = 16'h1111;
        tick(); rom_valid = 1'b0;
        chk1("rom_write_dtack", cpu_dtack_n, 1'b0);
        chk("rom_write_din_held", cpu_din, 16'hFF5A);
        end_acc();

        // Abort in ROM_WAIT, stray rom_valid afterwards
        begin_acc(1'b1, 4'b1000);
        tick(); tick(); tick();
        cpu_as_n = 1'b1; {rom_cs, ram_cs, shared_ram_cs, io_cs} = 4'b0000;
        tick(); tick();
        rom_valid = 1'b1; rom_data = 16'hDEAD;
        tick(); rom_valid = 1'b0;
        repeat (3) tick();
        chk1("abort_no_dtack", cpu_dtack_n, 1'b1);
        chk("abort_din_held", cpu_din, 16'hFF5A);

        // rom_valid coincident with AS release: abort wins
        begin_acc(1'b1, 4'b1000);
        tick(); tick();
        cpu_as_n = 1'b1; {rom_cs, ram_cs, shared_ram_cs, io_cs} = 4'b0000;
        rom_valid = 1'b1; rom_data = 16'hBAD0;
        tick(); rom_valid = 1'b0;
        chk1("coincident_abort_dtack", cpu_dtack_n, 1'b1);
        chk("coincident_abort_din", cpu_din, 16'hFF5A);
        tick();

        // IO read after aborts
        io_data = 16'hC0DE;
        begin_acc(1'b1, 4'b0001);
        wait_ack(lat);
        chk_int("io_read_latency", lat, 2);
        chk("io_read_data", cpu_din, 16'hC0DE);
        end_acc();

        // Unmapped read
        begin_acc(1'b1, 4'b0000);
        wait_ack(lat);
        if (BERR_MODE) begin
            chk_int("unmapped_berr_latency", lat, BERR_T + 2);
            chk1("unmapped_berr_n", cpu_berr_n, 1'b0);
            chk1("unmapped_no_dtack", cpu_dtack_n, 1'b1);
            chk("unmapped_din_held", cpu_din, 16'hC0DE);
        end else begin
            chk_int("unmapped_latency", lat, IO_W + 2);
            chk1("unmapped_dtack", cpu_dtack_n, 1'b0);
            chk1("unmapped_berr_idle", cpu_berr_n, 1'b1);
            chk("unmapped_open_bus", cpu_din, 16'hFFFF);
        end
        tick();
        end_acc();

        // Reset while in ACK
        ram_data = 16'h2222;
        begin_acc(1'b1, 4'b0100);
        wait_ack(lat);
        chk_int("pre_reset_latency", lat, 3);
        reset = 1'b1; cpu_as_n = 1'b1; {rom_cs, ram_cs, shared_ram_cs, io_cs} = 4'b0000;
        tick();
        chk1("reset_ack_dtack_n", cpu_dtack_n, 1'b1);
        chk("reset_ack_din", cpu_din, 16'h0000);
        chk1("reset_ack_rom_req", rom_req, 1'b0);
        reset = 1'b0;
        tick();

        // Accesses after reset: read, then write keeps data
        ram_data = 16'h3333;
        begin_acc(1'b1, 4'b0100);
        wait_ack(lat);
        chk_int("post_reset_latency", lat, 3);
        chk("post_reset_data", cpu_din, 16'h3333);
        end_acc();
        ram_data = 16'h4444;
        begin_acc(1'b0, 4'b0100);
        wait_ack(lat);
        chk_int("ram_write_latency", lat, 3);
        chk("ram_write_din_held", cpu_din, 16'h3333);
        end_acc();

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
